// File: rtl/rv_exec_regfile.sv
// rv32emc execute stage: integer register file plus RV32IM ALU.
// Define RV_ALU_MULDIV_EN to build the multiplier and iterative divider.
module rv_exec_regfile #(
    parameter int unsigned Nregs = 16
) (
    input  logic        clk,
    input  logic        xreset,
    input  logic [4:0]  ars1,
    input  logic [4:0]  ars2,
    output logic [31:0] rs1,
    output logic [31:0] rs2,
    input  logic [4:0]  awd,
    input  logic        we,
    input  logic [31:0] wd,
    input  logic        rdy,
    input  logic [4:0]  alu,
    input  logic [31:0] rrd1,
    input  logic [31:0] rrd2,
    input  logic [31:0] csr_rd,
    output logic [31:0] rwdat,
    output logic [31:0] rwdatx,
    output logic        cmpl,
    output logic        mulop
);

    localparam int unsigned AW = (Nregs > 1) ? $clog2(Nregs) : 1;

    logic [31:0] regs [Nregs];
    logic        rd1_ok, rd2_ok, wr_ok;
    logic [31:0] alu_res;
    logic [31:0] div_res;
    logic [4:0]  sh;
    logic        is_div;

    assign rd1_ok = (ars1 != '0) && (32'(ars1) < Nregs);
    assign rd2_ok = (ars2 != '0) && (32'(ars2) < Nregs);
    assign wr_ok  = we && (awd != '0) && (32'(awd) < Nregs);
    assign rs1    = rd1_ok ? regs[ars1[AW-1:0]] : '0;
    assign rs2    = rd2_ok ? regs[ars2[AW-1:0]] : '0;

    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) begin
            for (int unsigned i = 0; i < Nregs; i++) regs[i] <= '0;
        end else if (wr_ok) begin
            regs[awd[AW-1:0]] <= wd;
        end
    end

    assign sh     = rrd2[4:0];
    assign is_div = (alu >= 5'd16) && (alu <= 5'd19);

    always_comb begin
        alu_res = '0;
        case (alu)
            5'd1:    alu_res = rrd1 + rrd2;
            5'd2:    alu_res = rrd1 - rrd2;
            5'd3:    alu_res = rrd1 << sh;
            5'd4:    alu_res = {31'b0, ($signed(rrd1) < $signed(rrd2))};
            5'd5:    alu_res = {31'b0, (rrd1 < rrd2)};
            5'd6:    alu_res = rrd1 ^ rrd2;
            5'd7:    alu_res = rrd1 >> sh;
            5'd8:    alu_res = $unsigned($signed(rrd1) >>> sh);
            5'd9:    alu_res = rrd1 | rrd2;
            5'd10:   alu_res = rrd1 & rrd2;
            5'd11:   alu_res = csr_rd;
            default: alu_res = '0;
        endcase
    end

    assign rwdat = cmpl ? div_res : alu_res;

`ifdef RV_ALU_MULDIV_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

    div_state_t  state, state_nx;
    logic        a_sx, b_sx;
    logic signed [63:0] ma, mb, prod;
    logic        div_sgn;
    logic [4:0]  cnt;
    logic [31:0] dq, dr, dd;
    logic        rem_op, neg_q, neg_r;
    logic [32:0] r_sh;
    logic        q_ok;

    assign mulop = (alu >= 5'd12) && (alu <= 5'd15);
    // 64x64 product of sign/zero-extended operands covers all four MUL variants
    assign a_sx  = ((alu == 5'd13) || (alu == 5'd14)) && rrd1[31];
    assign b_sx  = (alu == 5'd13) && rrd2[31];
    assign ma    = {{32{a_sx}}, rrd1};
    assign mb    = {{32{b_sx}}, rrd2};
    assign prod  = ma * mb;

    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) begin
            rwdatx <= '0;
        end else if (rdy) begin
            rwdatx <= (alu == 5'd12) ? prod[31:0] : prod[63:32];
        end
    end

    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (rdy) begin
            case (state)
                IDLE:    if (is_div) state_nx = BUSY;
                BUSY:    if (cnt == 5'd31) state_nx = DONE;
                DONE:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    assign div_sgn = (alu == 5'd16) || (alu == 5'd18);
    assign r_sh    = {dr, dq[31]};
    assign q_ok    = r_sh >= {1'b0, dd};

    // Divide on magnitudes; signs are reapplied at the output
    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) begin
            cnt    <= '0;
            dq     <= '0;
            dr     <= '0;
            dd     <= '0;
            rem_op <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else if (rdy) begin
            if (state == IDLE && is_div) begin
                cnt    <= '0;
                dr     <= '0;
                dq     <= (div_sgn && rrd1[31]) ? -rrd1 : rrd1;
                dd     <= (div_sgn && rrd2[31]) ? -rrd2 : rrd2;
                rem_op <= alu[1];
                neg_q  <= div_sgn && (rrd1[31] ^ rrd2[31]) && (rrd2 != '0);
                neg_r  <= div_sgn && rrd1[31];
            end else if (state == BUSY) begin
                dq  <= {dq[30:0], q_ok};
                dr  <= q_ok ? 32'(r_sh - {1'b0, dd}) : r_sh[31:0];
                cnt <= cnt + 5'd1;
            end
        end
    end

    assign cmpl    = (state == DONE);
    assign div_res = rem_op ? (neg_r ? -dr : dr) : (neg_q ? -dq : dq);
`else
    logic cmpl_q;

    // Divide ops still handshake so the pipeline cannot stall forever
    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset)  cmpl_q <= 1'b0;
        else if (rdy) cmpl_q <= is_div && !cmpl_q;
    end

    assign cmpl    = cmpl_q;
    assign div_res = '0;
    assign mulop   = 1'b0;
    assign rwdatx  = '0;
`endif

endmodule

// File: tb/tb_rv_exec_regfile.sv
// Randomized self-checking bench for rv_exec_regfile against a behavioural model.
// Expectations follow RV_ALU_MULDIV_EN the same way the design does.
module tb_rv_exec_regfile;

    localparam int unsigned NREGS = 16;
`ifdef RV_ALU_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic        clk, xreset;
    logic [4:0]  ars1, ars2, awd, alu;
    logic [31:0] rs1, rs2, wd, rrd1, rrd2, csr_rd, rwdat, rwdatx;
    logic        we, rdy, cmpl, mulop;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] mdl [32];

    rv_exec_regfile #(.Nregs(NREGS)) dut (
        .clk(clk), .xreset(xreset),
        .ars1(ars1), .ars2(ars2), .rs1(rs1), .rs2(rs2),
        .awd(awd), .we(we), .wd(wd),
        .rdy(rdy), .alu(alu), .rrd1(rrd1), .rrd2(rrd2), .csr_rd(csr_rd),
        .rwdat(rwdat), .rwdatx(rwdatx), .cmpl(cmpl), .mulop(mulop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rf_rd(input logic [4:0] ad);
        return (ad != 5'd0 && 32'(ad) < NREGS) ? mdl[ad] : 32'h0;
    endfunction

    function automatic void rf_wr(input logic w, input logic [4:0] ad, input logic [31:0] d);
        if (w && ad != 5'd0 && 32'(ad) < NREGS) mdl[ad] = d;
    endfunction

    function automatic void rf_clear();
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] c);
        longint sa;
        int unsigned amt;
        sa  = longint'($signed(a));
        amt = int'(b[4:0]);
        case (op)
            5'd1:    return a + b;
            5'd2:    return a - b;
            5'd3:    return a << amt;
            5'd4:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd5:    return (a < b) ? 32'd1 : 32'd0;
            5'd6:    return a ^ b;
            5'd7:    return a >> amt;
            5'd8:    return 32'(sa / (longint'(1) << amt) - ((sa < 0 && (sa % (longint'(1) << amt)) != 0) ? 1 : 0));
            5'd9:    return a | b;
            5'd10:   return a & b;
            5'd11:   return c;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] ref_mul(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        case (op)
            5'd12:   p = sa * sb;
            5'd13:   p = sa * sb;
            5'd14:   p = sa * ub;
            default: p = ua * ub;
        endcase
        return (op == 5'd12) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] ref_div(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        bit is_rem;
        is_rem = (op == 5'd18) || (op == 5'd19);
        if (b == 32'h0) return is_rem ? a : 32'hFFFF_FFFF;
        if (op == 5'd16 || op == 5'd18) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return is_rem ? 32'h0 : 32'h8000_0000;
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return is_rem ? 32'(sa % sb) : 32'(sa / sb);
        end
        return is_rem ? (a % b) : (a / b);
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return 32'($urandom_range(0, 40));
            2: case ($urandom_range(0, 4))
                   0: return 32'h0;
                   1: return 32'h1;
                   2: return 32'hFFFF_FFFF;
                   3: return 32'h8000_0000;
                   default: return 32'h7FFF_FFFF;
               endcase
            default: return -32'($urandom_range(1, 40));
        endcase
    endfunction

    task automatic wr(input logic [4:0] ad, input logic [31:0] d);
        we = 1'b1; awd = ad; wd = d;
        tick();
        rf_wr(1'b1, ad, d);
        we = 1'b0;
    endtask

    task automatic alu_chk(input string tag, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] c);
        alu = op; rrd1 = a; rrd2 = b; csr_rd = c; rdy = 1'b1;
        #1;
        chk(tag, rwdat, ref_alu(op, a, b, c));
    endtask

    task automatic mul_chk(input string tag, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        alu = op; rrd1 = a; rrd2 = b; rdy = 1'b1;
        #1;
        chk({tag, "_mulop"}, {31'b0, mulop}, {31'b0, MD});
        chk({tag, "_rwdat"}, rwdat, 32'h0);
        tick();
        chk({tag, "_x"}, rwdatx, MD ? ref_mul(op, a, b) : 32'h0);
    endtask

    task automatic run_div(input string tag, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input bit stall);
        int lat;
        int exp_lat;
        we = 1'b0; alu = op; rrd1 = a; rrd2 = b; rdy = 1'b1;
        tick();
        alu = 5'd0; rrd1 = $urandom; rrd2 = $urandom;
        lat = 1;
        while (cmpl !== 1'b1 && lat < 100) begin
            if (stall && lat == 10) rdy = 1'b0;
            if (stall && lat == 15) rdy = 1'b1;
            tick();
            lat++;
        end
        exp_lat = MD ? (stall ? 38 : 33) : 1;
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_res"}, rwdat, MD ? ref_div(op, a, b) : 32'h0);
        rdy = 1'b1;
        tick();
        chk({tag, "_pulse"}, {31'b0, cmpl}, 32'h0);
    endtask

    initial begin
        logic [4:0]  op;
        logic [31:0] a, b, exp_x;
        bit          x_valid;
        int          ncmpl;

        xreset = 1'b0; we = 1'b0; awd = '0; wd = '0; ars1 = '0; ars2 = '0;
        rdy = 1'b0; alu = '0; rrd1 = '0; rrd2 = '0; csr_rd = '0;
        rf_clear();
        repeat (2) @(posedge clk);
        #1;
        ars1 = 5'd5; ars2 = 5'd15;
        #1;
        chk("rst_rs1", rs1, 32'h0);
        chk("rst_rs2", rs2, 32'h0);
        chk("rst_rwdatx", rwdatx, 32'h0);
        chk("rst_cmpl", {31'b0, cmpl}, 32'h0);
        xreset = 1'b1;
        tick();

        // register file directed cases
        wr(5'd5, 32'h1234_5678);
        ars1 = 5'd5; #1;
        chk("rf_x5", rs1, 32'h1234_5678);
        wr(5'd0, 32'hDEAD_BEEF);
        ars1 = 5'd0; #1;
        chk("rf_x0", rs1, 32'h0);
        wr(5'd20, 32'hCAFE_F00D);
        ars1 = 5'd20; ars2 = 5'd4; #1;
        chk("rf_x20", rs1, 32'h0);
        chk("rf_x4_alias", rs2, rf_rd(5'd4));
        wr(5'd3, 32'h1);
        we = 1'b1; awd = 5'd3; wd = 32'h7; ars1 = 5'd3; #1;
        chk("rf_x3_old", rs1, 32'h1);
        tick();
        rf_wr(1'b1, 5'd3, 32'h7);
        chk("rf_x3_new", rs1, 32'h7);
        we = 1'b0;

        // ALU directed cases
        alu_chk("add_wrap", 5'd1, 32'hFFFF_FFFF, 32'h1, 32'h0);
        alu_chk("sra", 5'd8, 32'h8000_0000, 32'd4, 32'h0);
        alu_chk("slt", 5'd4, 32'hFFFF_FFFF, 32'h1, 32'h0);
        alu_chk("sltu", 5'd5, 32'hFFFF_FFFF, 32'h1, 32'h0);
        alu_chk("csr", 5'd11, 32'h5, 32'h6, 32'h0000_ABCD);

        mul_chk("mulh", 5'd13, 32'h8000_0000, 32'h2);
        mul_chk("mul", 5'd12, 32'd7, 32'd6);
        alu = 5'd12; rrd1 = 32'd9; rrd2 = 32'd9; rdy = 1'b0;
        tick();
        chk("mul_hold", rwdatx, MD ? 32'd42 : 32'h0);
        rdy = 1'b1;

        // divide directed cases
        run_div("div_neg", 5'd16, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_div("rem_neg", 5'd18, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_div("divu_z", 5'd17, 32'd5, 32'h0, 1'b0);
        run_div("remu_z", 5'd19, 32'd5, 32'h0, 1'b0);
        run_div("div_ovf", 5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_div("rem_ovf", 5'd18, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_div("div_stall", 5'd17, 32'd100, 32'd7, 1'b1);
        for (int i = 0; i < 6; i++) begin
            op = 5'(16 + $urandom_range(0, 3));
            run_div($sformatf("div_rnd%0d", i), op, pick(), pick(), 1'b0);
        end

        // reset in the middle of a divide
        alu = 5'd16; rrd1 = 32'd1000; rrd2 = 32'd3; rdy = 1'b1;
        tick();
        alu = 5'd0;
        repeat (10) tick();
        xreset = 1'b0;
        rf_clear();
        ars1 = 5'd5; #1;
        chk("mid_rst_cmpl", {31'b0, cmpl}, 32'h0);
        chk("mid_rst_rf", rs1, 32'h0);
        xreset = 1'b1;
        ncmpl = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (cmpl === 1'b1) ncmpl++;
        end
        chk("mid_rst_nocmpl", 32'(ncmpl), 32'h0);
        run_div("after_rst", 5'd16, 32'd1000, 32'd3, 1'b0);

        // randomized mixed traffic
        x_valid = 1'b0;
        exp_x   = 32'h0;
        for (int i = 0; i < 300; i++) begin
            op = 5'($urandom_range(0, 31));
            if (op >= 5'd16 && op <= 5'd19) op = op - 5'd16;
            a = pick(); b = pick();
            alu = op; rrd1 = a; rrd2 = b; csr_rd = $urandom;
            rdy  = ($urandom_range(0, 3) != 0);
            we   = 1'($urandom_range(0, 1));
            awd  = 5'($urandom_range(0, 31));
            wd   = $urandom;
            ars1 = 5'($urandom_range(0, 31));
            ars2 = 5'($urandom_range(0, 31));
            #1;
            chk($sformatf("r%0d_rs1", i), rs1, rf_rd(ars1));
            chk($sformatf("r%0d_rs2", i), rs2, rf_rd(ars2));
            chk($sformatf("r%0d_rwdat", i), rwdat, ref_alu(op, a, b, csr_rd));
            chk($sformatf("r%0d_mulop", i), {31'b0, mulop},
                {31'b0, MD && op >= 5'd12 && op <= 5'd15});
            chk($sformatf("r%0d_cmpl", i), {31'b0, cmpl}, 32'h0);
            tick();
            rf_wr(we, awd, wd);
            if (rdy) begin
                x_valid = (op >= 5'd12 && op <= 5'd15);
                exp_x   = MD ? ref_mul(op, a, b) : 32'h0;
            end
            if (x_valid) chk($sformatf("r%0d_rwdatx", i), rwdatx, exp_x);
        end
        we = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
